scan_doubler: RTL



---
 rtl/scan_doubler_pkg.sv | 24 ++
 rtl/scan_doubler_linebuf.sv | 25 ++
 rtl/scan_doubler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/scan_doubler_pkg.sv
// Shared constants for the scan doubler: RGB332 field positions, sync polarity
// and the scanline dimming helper.
package scan_doubler_pkg;

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Halve each colour field independently so no field borrows from its neighbour.
    function automatic logic [7:0] dim_rgb332(input logic [7:0] px);
        logic [7:0] d;
        d = '0;
        d[R_HI:R_LO] = px[R_HI:R_LO] >> 1;
        d[G_HI:G_LO] = px[G_HI:G_LO] >> 1;
        d[B_HI:B_LO] = px[B_HI:B_LO] >> 1;
        return d;
    endfunction

endpackage

// File: rtl/scan_doubler_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, 2^(AW+1) x DW, bank in address MSB.
// Synchronous write, registered read.
module sd_linebuf
    import scan_doubler_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          MCLK,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<(AW+1))-1];

    always_ff @(posedge MCLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/scan_doubler.sv
// 15 kHz -> 31 kHz scan doubler: captures each input line and replays it twice.
// Optional scanline dimming of the second repetition: SCAN_DOUBLER_SCANLINES_EN.
module scan_doubler
    import scan_doubler_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          PCLK_EN,
    input  logic          DCLK_EN,
    input  logic [DW-1:0] iRGB,
    input  logic          iHBLK,
    input  logic          iVBLK,
    input  logic          iHSYN,
    input  logic          iVSYN,
    input  logic          SL_ENA,
    output logic [DW-1:0] oRGB,
    output logic          oHBLK,
    output logic          oVBLK,
    output logic          oHSYN,
    output logic          oVSYN
);

    logic          hblk_d, hsyn_d;
    logic [AW-1:0] icnt, idx_cur;
    logic [AW:0]   wcnt;
    logic [AW-1:0] hbe, hbs, hsw, hbe_r, hbs_r, hsw_r;
    logic [AW:0]   len;
    logic          bank, seen, valid;
    logic          hsyn_fall, hsyn_rise, wr_en;

    logic [AW:0]   ocnt;
    logic          half;
    logic [AW-1:0] rcnt, rd_idx;
    logic          in_win, in_sync, rd_en;
    logic [DW-1:0] rdata, pix;

    assign hsyn_fall = PCLK_EN && (hsyn_d != SYNC_ACTIVE) && (iHSYN == SYNC_ACTIVE);
    assign hsyn_rise = (hsyn_d == SYNC_ACTIVE) && (iHSYN != SYNC_ACTIVE);
    // Index of the pixel being presented; the HSYN-fall pixel is index 0.
    assign idx_cur   = hsyn_fall ? '0 :
                       (icnt == {AW{1'b1}}) ? icnt : icnt + 1'b1;
    assign wr_en     = PCLK_EN && !iHBLK && !wcnt[AW];

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            hblk_d <= 1'b1;
            hsyn_d <= 1'b1;
            icnt   <= '0;
            wcnt   <= '0;
            hbe    <= '0;
            hbs    <= '0;
            hsw    <= '0;
            hbe_r  <= '0;
            hbs_r  <= '0;
            hsw_r  <= '0;
            len    <= '0;
            bank   <= 1'b0;
            seen   <= 1'b0;
            valid  <= 1'b0;
            oVBLK  <= 1'b1;
            oVSYN  <= 1'b1;
        end else if (PCLK_EN) begin
            hblk_d <= iHBLK;
            hsyn_d <= iHSYN;
            icnt   <= idx_cur;
            if (hblk_d && !iHBLK) hbe <= idx_cur;
            if (!hblk_d && iHBLK) hbs <= idx_cur;
            if (hsyn_rise)        hsw <= idx_cur;
            if (hsyn_fall) begin
                len   <= {1'b0, icnt} + 1'b1;
                hbe_r <= hbe;
                hbs_r <= hbs;
                hsw_r <= hsw;
                bank  <= ~bank;
                wcnt  <= '0;
                seen  <= 1'b1;
                valid <= seen;
                oVBLK <= iVBLK;
                oVSYN <= iVSYN;
            end else if (wr_en) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    assign in_win  = ({1'b0, hbe_r} <= ocnt) && (ocnt < {1'b0, hbs_r});
    assign in_sync = ocnt < {1'b0, hsw_r};
    assign rd_idx  = (ocnt == '0) ? '0 : rcnt;
    assign rd_en   = DCLK_EN && valid && in_win;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            ocnt  <= '0;
            half  <= 1'b0;
            rcnt  <= '0;
            oHBLK <= 1'b1;
            oHSYN <= 1'b1;
        end else begin
            if (DCLK_EN) begin
                oHBLK <= !(valid && in_win);
                oHSYN <= (valid && in_sync) ? SYNC_ACTIVE : !SYNC_ACTIVE;
                rcnt  <= (valid && in_win) ? rd_idx + 1'b1 : rd_idx;
                if (ocnt == len - 1'b1) begin
                    ocnt <= '0;
                    half <= ~half;
                end else begin
                    ocnt <= ocnt + 1'b1;
                end
            end
            // Input line start wins over any same-cycle output advance.
            if (hsyn_fall) begin
                ocnt <= '0;
                half <= 1'b0;
            end
        end
    end

    sd_linebuf #(.AW(AW), .DW(DW)) u_linebuf (
        .MCLK  (MCLK),
        .we    (wr_en),
        .waddr ({bank, wcnt[AW-1:0]}),
        .wdata (iRGB),
        .re    (rd_en),
        .raddr ({~bank, rd_idx}),
        .rdata (rdata)
    );

`ifdef SCAN_DOUBLER_SCANLINES_EN
    logic sl_q, half_q;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            sl_q   <= 1'b0;
            half_q <= 1'b0;
        end else if (DCLK_EN) begin
            sl_q   <= SL_ENA;
            half_q <= half;
        end
    end

    assign pix = (sl_q && half_q) ? dim_rgb332(rdata) : rdata;
`else
    logic unused_sl;
    assign unused_sl = SL_ENA;
    assign pix       = rdata;
`endif

    assign oRGB = oHBLK ? '0 : pix;

endmodule
